mmio_hub: RTL and testbench
===========================

# mmio_hub

Parametrised memory-mapped I/O hub between the processor's data-memory port and the board peripherals. It decodes a contiguous register window starting at a base address. It provides debounced sticky button events with clear-on-read, a millisecond countdown timer, a read-only random-number passthrough, and NUM_OUT latched output channels with one-cycle write strobes. The wrapper muxes its registered read data over RAM data whenever `rd_hit` is high.

## Interface
- ADDR_W, 12, data-memory address width
- BASE_ADDR, 5, word address of register offset 0
- NUM_IN, 4, button inputs (1..16)
- NUM_OUT, 4, output channels (1..16)
- CHAN_W, 8, bits latched per output channel (1..32)
- DEB_CYCLES, 16, consecutive stable samples required to accept a level change (≥2)
- TICK_DIV, 50000, clock cycles per timer decrement (≥1)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- addr  in  ADDR_W  data-memory address
- wren  in  1  store strobe
- rd_en  in  1  load strobe; clear-on-read side effects occur only when this is high
- data_in  in  32  store data
- rand_in  in  32  random value from LFSR
- buttons  in  NUM_IN  raw asynchronous button levels
- rd_data  out  32  registered read data
- rd_hit  out  1  registered; high when rd_data is valid for a window access
- chan_data  out  NUM_OUT*CHAN_W  latched channel values; channel k occupies [k*CHAN_W +: CHAN_W]
- chan_stb  out  NUM_OUT  one-cycle pulse per channel write
- timer_done  out  1  sticky timer-expired flag

## Operation
- Decode: off = addr − BASE_ADDR. An access is in-window when BASE_ADDR ≤ addr < BASE_ADDR+4+NUM_OUT. Out-of-window accesses have no effect.
- Register map:
  - +0 RAND: read only, returns rand_in.
  - +1 BUTTONS: pending mask in [NUM_IN-1:0]; upper bits 0.
  - +2 TIMER: write loads data_in[15:0]; read returns the current count.
  - +3 STATUS: bit0 = timer_done; bits[8+NUM_IN-1:8] = debounced levels.
  - +4+k: CHAN k.
- Writes to RAND, BUTTONS and STATUS are ignored.
- Input path, per button:
  - 2-flop synchroniser, then a debounce counter.
  - When the synchronised value differs from the debounced level for DEB_CYCLES consecutive cycles, the debounced level flips. Any agreeing sample resets the counter.
  - A 0→1 debounced transition sets pending[i].
- BUTTONS read clears the bits in the returned snapshot: pending ← (pending & ~snapshot) | new_rises. A rise in the read cycle survives.
- Timer:
  - A prescaler counts 0..TICK_DIV−1; on wrap, count decrements if nonzero.
  - A 1→0 decrement sets timer_done.
  - A TIMER write loads count, zeroes the prescaler and clears timer_done. Loading 0 does not set done.
  - Write wins over a same-cycle tick.
  - A STATUS read (rd_en) clears timer_done after returning it. A set occurring in the same cycle wins.
- Channels: a write to +4+k latches data_in[CHAN_W-1:0] into chan k and pulses chan_stb[k] in the next cycle. Reading returns the latched value, zero-extended.
- wren and rd_en both high: the write is performed and read data is returned. The BUTTONS clear still applies.

## Timing
- Read latency 1: rd_data and rd_hit are registered from the edge on which an in-window (rd_en|wren) access is sampled.
  - Out-of-window access: rd_hit=0, rd_data=0.
  - No access: rd_hit=0, rd_data=0.
- chan_stb[k] is high exactly one cycle, the cycle after the write edge. chan_data updates on the same edge.
- Press-to-pending latency: 2 (sync) + DEB_CYCLES cycles after a stable level change.
- Timer expiry: a load of N with no further writes sets timer_done N·TICK_DIV cycles after the load edge.
- Reset values: rd_data=0, rd_hit=0, chan_data=0, chan_stb=0, timer_done=0. Pending, debounced levels, counters, prescaler and timer count are also 0.
- Reset mid-operation overrides every concurrent write, read or tick in that cycle.

## Test plan
- Reset then read +0 with rand_in=0xDEADBEEF → next cycle rd_hit=1, rd_data=0xDEADBEEF. Read addr 4 → rd_hit=0, rd_data=0.
- buttons[2] high for 20 cycles (DEB_CYCLES=16) → pending=0x4 after 18 cycles. Read +1 → 0x4, then 0x0. A 10-cycle glitch on buttons[1] → no pending.
- Rise on buttons[0] landing in the same cycle as a BUTTONS read returning 0x4 → following read returns 0x1.
- TICK_DIV=4: write TIMER=3 → timer_done rises 12 cycles later. Read STATUS → bit0=1, then 0. Rewrite at cycle 11 → done stays 0.
- Write 0xA5 to +4+2 → chan_stb=0b0100 for exactly one cycle, chan_data[23:16]=0xA5. Readback returns 0x000000A5. Writes to +0/+1/+3 change nothing.
- Assert reset during an active countdown with a pending press → all outputs and state return to 0 on the next edge.

Source files
------------

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: register window decode, debounced button events,
// millisecond countdown timer, random passthrough and latched output channels.
module mmio_hub #(
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 5,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int CHAN_W     = 8,
  parameter int DEB_CYCLES = 16,
  parameter int TICK_DIV   = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      wren,
  input  logic                      rd_en,
  input  logic [31:0]               data_in,
  input  logic [31:0]               rand_in,
  input  logic [NUM_IN-1:0]         buttons,
  output logic [31:0]               rd_data,
  output logic                      rd_hit,
  output logic [NUM_OUT*CHAN_W-1:0] chan_data,
  output logic [NUM_OUT-1:0]        chan_stb,
  output logic                      timer_done
);

  localparam int          CW = $clog2(DEB_CYCLES);
  localparam int          PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [31:0] LO = 32'(BASE_ADDR);
  localparam logic [31:0] HI = 32'(BASE_ADDR + 4 + NUM_OUT);

  logic [31:0]        w_addr32;
  logic [31:0]        w_off;
  logic               w_inWin;
  logic               w_acc;
  logic               w_wr;
  logic               w_rd;
  logic               w_wrTimer;
  logic               w_rdBtn;
  logic               w_rdStatus;
  logic [NUM_OUT-1:0] w_chWr;

  logic [NUM_IN-1:0]  r_sync1;
  logic [NUM_IN-1:0]  r_sync2;
  logic [NUM_IN-1:0]  r_deb;
  logic [NUM_IN-1:0]  r_pend;
  logic [CW-1:0]      r_cnt [NUM_IN];
  logic [CW-1:0]      w_cntNext [NUM_IN];
  logic [NUM_IN-1:0]  w_debNext;
  logic [NUM_IN-1:0]  w_rise;
  logic [NUM_IN-1:0]  w_pendNext;

  logic [PW-1:0]      r_presc;
  logic [15:0]        r_count;
  logic               r_done;
  logic               w_tick;

  logic [CHAN_W-1:0]  r_chan [NUM_OUT];
  logic [NUM_OUT-1:0] r_stb;
  logic [31:0]        r_rdData;
  logic               r_rdHit;
  logic [31:0]        w_status;
  logic [31:0]        w_rdMux;
  logic               w_unused;

  // Window bounds are checked on the absolute address so addresses below the
  // base cannot alias into the window through offset wraparound.
  assign w_addr32   = 32'(addr);
  assign w_inWin    = (w_addr32 >= LO) && (w_addr32 < HI);
  assign w_off      = w_addr32 - LO;
  assign w_acc      = (rd_en | wren) & w_inWin;
  assign w_wr       = wren & w_inWin;
  assign w_rd       = rd_en & w_inWin;
  assign w_wrTimer  = w_wr && (w_off == 32'd2);
  assign w_rdBtn    = w_rd && (w_off == 32'd1);
  assign w_rdStatus = w_rd && (w_off == 32'd3);
  assign w_unused   = ^{data_in, w_off};

  always_comb begin
    w_chWr = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_chWr[k] = w_wr && (w_off == 32'(4 + k));
    end
  end

  // A level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    w_debNext = r_deb;
    for (int i = 0; i < NUM_IN; i++) begin
      w_cntNext[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          w_debNext[i] = r_sync2[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise     = w_debNext & ~r_deb;
  assign w_pendNext = (r_pend & ~(w_rdBtn ? r_pend : '0)) | w_rise;
  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_pend  <= '0;
      for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      r_deb   <= w_debNext;
      r_pend  <= w_pendNext;
      for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= w_cntNext[i];
    end
  end

  // Priority: load beats expiry, expiry beats the STATUS clear-on-read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (w_wrTimer) begin
      r_presc <= '0;
      r_count <= data_in[15:0];
      r_done  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick && (r_count != 16'd0)) begin
        r_count <= r_count - 16'd1;
      end
      if (w_tick && (r_count == 16'd1)) begin
        r_done <= 1'b1;
      end else if (w_rdStatus) begin
        r_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stb <= '0;
      for (int k = 0; k < NUM_OUT; k++) r_chan[k] <= '0;
    end else begin
      r_stb <= w_chWr;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_chWr[k]) r_chan[k] <= data_in[CHAN_W-1:0];
      end
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[0]             = r_done;
    w_status[8 +: NUM_IN]   = r_deb;
  end

  always_comb begin
    w_rdMux = '0;
    case (w_off)
      32'd0:   w_rdMux = rand_in;
      32'd1:   w_rdMux = 32'(r_pend);
      32'd2:   w_rdMux = 32'(r_count);
      32'd3:   w_rdMux = w_status;
      default: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (w_off == 32'(4 + k)) w_rdMux = 32'(r_chan[k]);
        end
      end
    endcase
  end

  // Any in-window access, including a pure store, returns the pre-edge value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdData <= '0;
      r_rdHit  <= 1'b0;
    end else begin
      r_rdData <= w_acc ? w_rdMux : '0;
      r_rdHit  <= w_acc;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chanOut
    assign chan_data[k*CHAN_W +: CHAN_W] = r_chan[k];
  end

  assign rd_data    = r_rdData;
  assign rd_hit     = r_rdHit;
  assign chan_stb   = r_stb;
  assign timer_done = r_done;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed testbench for mmio_hub with hand-computed expectations
// (DEB_CYCLES=16, TICK_DIV=4, BASE_ADDR=5, four 8-bit channels).
module tb_mmio_hub;

  logic        clock;
  logic        reset;
  logic [11:0] addr;
  logic        wren;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] rand_in;
  logic [3:0]  buttons;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [31:0] chan_data;
  logic [3:0]  chan_stb;
  logic        timer_done;

  int nCompared;
  int nMismatched;

  mmio_hub #(
    .ADDR_W(12), .BASE_ADDR(5), .NUM_IN(4), .NUM_OUT(4), .CHAN_W(8),
    .DEB_CYCLES(16), .TICK_DIV(4)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wren(wren), .rd_en(rd_en),
    .data_in(data_in), .rand_in(rand_in), .buttons(buttons),
    .rd_data(rd_data), .rd_hit(rd_hit), .chan_data(chan_data),
    .chan_stb(chan_stb), .timer_done(timer_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doRead(input logic [11:0] a);
    addr = a; rd_en = 1'b1; wren = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic doWrite(input logic [11:0] a, input logic [31:0] d);
    addr = a; data_in = d; wren = 1'b1; rd_en = 1'b0;
    tick();
    wren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
    nCompared++; if (rd_hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rd_hit: got %b want 0", rd_hit); end
    nCompared++; if (chan_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_chan_data: got %h want 0", chan_data); end
    nCompared++; if (chan_stb !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_chan_stb: got %b want 0", chan_stb); end
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_timer_done: got %b want 0", timer_done); end
    reset = 1'b0;
    doRead(12'd7);
    nCompared++; if (rd_data !== 32'h0 || rd_hit !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_count: got %h/%b want 0/1", rd_data, rd_hit); end
  endtask

  task automatic test_rand();
    rand_in = 32'hDEADBEEF;
    doRead(12'd5);
    nCompared++; if (rd_hit !== 1'b1 || rd_data !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL rand_read: got %h/%b want deadbeef/1", rd_data, rd_hit); end
    doRead(12'd4);
    nCompared++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL below_window: got %h/%b want 0/0", rd_data, rd_hit); end
    doRead(12'd13);
    nCompared++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL above_window: got %h/%b want 0/0", rd_data, rd_hit); end
    doRead(12'd12);
    nCompared++; if (rd_hit !== 1'b1 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL last_in_window: got %h/%b want 0/1", rd_data, rd_hit); end
    tick();
    nCompared++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL idle_no_access: got %h/%b want 0/0", rd_data, rd_hit); end
  endtask

  task automatic test_buttons();
    buttons[2] = 1'b1;
    repeat (17) tick();
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL btn_early: got %h want 0", rd_data); end
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h4) begin nMismatched++; $display("[TB] FAIL btn_pending: got %h want 4", rd_data); end
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL btn_cleared: got %h want 0", rd_data); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h400) begin nMismatched++; $display("[TB] FAIL btn_level: got %h want 400", rd_data); end
    buttons[2] = 1'b0;
    repeat (20) tick();
    buttons[1] = 1'b1;
    repeat (10) tick();
    buttons[1] = 1'b0;
    repeat (20) tick();
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL btn_glitch: got %h want 0", rd_data); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL btn_levels_low: got %h want 0", rd_data); end
  endtask

  task automatic test_rise_during_read();
    buttons[2] = 1'b1;
    repeat (18) tick();
    buttons[0] = 1'b1;
    repeat (17) tick();
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h4) begin nMismatched++; $display("[TB] FAIL rise_snapshot: got %h want 4", rd_data); end
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h1) begin nMismatched++; $display("[TB] FAIL rise_survives: got %h want 1", rd_data); end
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL rise_cleared: got %h want 0", rd_data); end
    buttons = 4'h0;
    repeat (20) tick();
  endtask

  task automatic test_timer();
    doWrite(12'd7, 32'd3);
    doRead(12'd7);
    nCompared++; if (rd_data !== 32'd3) begin nMismatched++; $display("[TB] FAIL timer_loaded: got %h want 3", rd_data); end
    repeat (10) tick();
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL timer_early: got %b want 0", timer_done); end
    tick();
    nCompared++; if (timer_done !== 1'b1) begin nMismatched++; $display("[TB] FAIL timer_expire: got %b want 1", timer_done); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h1) begin nMismatched++; $display("[TB] FAIL status_done: got %h want 1", rd_data); end
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL done_clear_on_read: got %b want 0", timer_done); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL status_after_clear: got %h want 0", rd_data); end
    doWrite(12'd7, 32'd3);
    repeat (10) tick();
    doWrite(12'd7, 32'd3);
    tick();
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL timer_rewrite: got %b want 0", timer_done); end
    repeat (10) tick();
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rewrite_early: got %b want 0", timer_done); end
    tick();
    nCompared++; if (timer_done !== 1'b1) begin nMismatched++; $display("[TB] FAIL rewrite_expire: got %b want 1", timer_done); end
    doWrite(12'd7, 32'd0);
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_clears_done: got %b want 0", timer_done); end
    repeat (10) tick();
    nCompared++; if (timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_zero: got %b want 0", timer_done); end
  endtask

  task automatic test_channels();
    doWrite(12'd11, 32'h000000A5);
    nCompared++; if (rd_hit !== 1'b1 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL write_returns_old: got %h/%b want 0/1", rd_data, rd_hit); end
    nCompared++; if (chan_stb !== 4'b0100) begin nMismatched++; $display("[TB] FAIL chan_stb_pulse: got %b want 0100", chan_stb); end
    nCompared++; if (chan_data !== 32'h00A50000) begin nMismatched++; $display("[TB] FAIL chan_data_a5: got %h want 00a50000", chan_data); end
    tick();
    nCompared++; if (chan_stb !== 4'b0000) begin nMismatched++; $display("[TB] FAIL chan_stb_one_cycle: got %b want 0000", chan_stb); end
    doRead(12'd11);
    nCompared++; if (rd_data !== 32'h000000A5) begin nMismatched++; $display("[TB] FAIL chan_readback: got %h want a5", rd_data); end
    doWrite(12'd9, 32'h000001FF);
    nCompared++; if (chan_data !== 32'h00A500FF || chan_stb !== 4'b0001) begin nMismatched++; $display("[TB] FAIL chan0_trunc: got %h/%b want 00a500ff/0001", chan_data, chan_stb); end
    doWrite(12'd5, 32'hFFFFFFFF);
    doWrite(12'd6, 32'hFFFFFFFF);
    doWrite(12'd8, 32'hFFFFFFFF);
    nCompared++; if (chan_data !== 32'h00A500FF || chan_stb !== 4'b0000 || timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL ro_writes: got %h/%b/%b want 00a500ff/0000/0", chan_data, chan_stb, timer_done); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL ro_status: got %h want 0", rd_data); end
    addr = 12'd12; data_in = 32'h3C; wren = 1'b1; rd_en = 1'b1;
    tick();
    wren = 1'b0; rd_en = 1'b0;
    nCompared++; if (rd_hit !== 1'b1 || rd_data !== 32'h0 || chan_stb !== 4'b1000) begin nMismatched++; $display("[TB] FAIL read_write: got %h/%b/%b want 0/1/1000", rd_data, rd_hit, chan_stb); end
    nCompared++; if (chan_data !== 32'h3CA500FF) begin nMismatched++; $display("[TB] FAIL read_write_data: got %h want 3ca500ff", chan_data); end
    doWrite(12'd13, 32'h77);
    nCompared++; if (rd_hit !== 1'b0 || chan_stb !== 4'b0 || chan_data !== 32'h3CA500FF) begin nMismatched++; $display("[TB] FAIL out_of_window_write: got %b/%b/%h want 0/0000/3ca500ff", rd_hit, chan_stb, chan_data); end
  endtask

  task automatic test_reset_mid();
    doWrite(12'd7, 32'd100);
    buttons[3] = 1'b1;
    repeat (18) tick();
    addr = 12'd10; data_in = 32'h55; wren = 1'b1; rd_en = 1'b1; reset = 1'b1; buttons = 4'h0;
    tick();
    wren = 1'b0; rd_en = 1'b0; reset = 1'b0;
    nCompared++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_reset_read: got %h/%b want 0/0", rd_data, rd_hit); end
    nCompared++; if (chan_data !== 32'h0 || chan_stb !== 4'h0 || timer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_outputs: got %h/%b/%b want 0/0/0", chan_data, chan_stb, timer_done); end
    doRead(12'd6);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_reset_pending: got %h want 0", rd_data); end
    doRead(12'd7);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_reset_count: got %h want 0", rd_data); end
    doRead(12'd8);
    nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_reset_status: got %h want 0", rd_data); end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b1; addr = '0; wren = 1'b0; rd_en = 1'b0;
    data_in = '0; rand_in = '0; buttons = '0;
    test_reset();
    test_rand();
    test_buttons();
    test_rise_during_read();
    test_timer();
    test_channels();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
